// File: rtl/apb_fifo_pkg.sv
// apb_fifo_pkg: register map, FSR field layout and bus-FSM states for apb_fifo_slave.
package apb_fifo_pkg;

    // Byte offsets of the memory-mapped registers (bits [1:0] are never decoded)
    localparam logic [31:0] FSR_OFS = 32'h0000_0000;
    localparam logic [31:0] FWD_OFS = 32'h0000_0004;
    localparam logic [31:0] FRD_OFS = 32'h0000_0008;

    // FSR field positions
    localparam int FSR_EMPTY_BIT = 0;
    localparam int FSR_FULL_BIT  = 1;
    localparam int FSR_CNT_LSB   = 8;
    localparam int FSR_CNT_W     = 8;

    // Bus FSM states; WAIT is only reachable when APB_FIFO_WAIT_EN is defined
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with show-ahead head. Pushes when full and pops
// when empty are dropped internally, so the caller cannot corrupt the pointers.
module fifo_sync #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are never visible because empty gates reads
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/apb_fifo_slave.sv
// apb_fifo_slave: APB3 completer exposing a FIFO through FSR (status),
// FWD (push) and FRD (pop). Define APB_FIFO_WAIT_EN to add one wait state
// per transfer; the default build completes with zero wait states.
module apb_fifo_slave
    import apb_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    apb_state_e        state_q, state_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic              push_pend_q, push_pend_d;
    logic              pop_pend_q, pop_pend_d;

    logic [31:0]       addr_word;
    logic              hit_fsr, hit_fwd, hit_frd;
    logic [31:0]       fsr_val;
    logic [31:0]       head_ext;

    logic              fifo_push, fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_pwdata;

    // Upper PWDATA bits beyond DATA_W are intentionally discarded
    assign unused_pwdata = ^PWDATA;

    assign addr_word = 32'(PADDR) & ~32'h3;
    assign hit_fsr   = (addr_word == FSR_OFS);
    assign hit_fwd   = (addr_word == FWD_OFS);
    assign hit_frd   = (addr_word == FRD_OFS);

    // Status word and zero-extended FIFO head
    always_comb begin
        fsr_val                             = '0;
        fsr_val[FSR_EMPTY_BIT]              = fifo_empty;
        fsr_val[FSR_FULL_BIT]               = fifo_full;
        fsr_val[FSR_CNT_LSB +: CNT_W]       = fifo_count;
        head_ext                            = '0;
        head_ext[DATA_W-1:0]                = fifo_rdata;
    end

    // Next-state logic: setup phase starts a transfer, RESP lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
`ifdef APB_FIFO_WAIT_EN
                    state_d = WAIT;
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef APB_FIFO_WAIT_EN
            WAIT:    state_d = PSEL ? RESP : IDLE;
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response decode, captured on the edge into RESP; zero outside RESP
    always_comb begin
        prdata_d    = '0;
        pslverr_d   = 1'b0;
        push_pend_d = 1'b0;
        pop_pend_d  = 1'b0;
        pready_d    = (state_d == RESP);
        if (state_d == RESP) begin
            if (PWRITE) begin
                if (hit_fwd) begin
                    if (fifo_full) pslverr_d   = 1'b1;
                    else           push_pend_d = 1'b1;
                end
            end else begin
                if (hit_fsr) begin
                    prdata_d = fsr_val;
                end else if (hit_frd) begin
                    if (fifo_empty) begin
                        pslverr_d = 1'b1;
                    end else begin
                        prdata_d   = head_ext;
                        pop_pend_d = 1'b1;
                    end
                end
            end
        end
    end

    // FSM and registered response outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            push_pend_q <= 1'b0;
            pop_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            push_pend_q <= push_pend_d;
            pop_pend_q  <= pop_pend_d;
        end
    end

    // Side effect commits on the edge ending RESP, only if the master is still in the access phase
    assign fifo_push = (state_q == RESP) & PSEL & PENABLE & push_pend_q;
    assign fifo_pop  = (state_q == RESP) & PSEL & PENABLE & pop_pend_q;

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

    fifo_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (PWDATA[DATA_W-1:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: doc/apb_fifo_slave.md
Name: apb_fifo_slave

Overview:
APB3 completer peripheral holding a synchronous data FIFO behind three memory-mapped registers. It is the responder to the CPU-side APB master on the MCU bus and sits on one PSEL line from the address decoder. Software pushes through a write-data register, pops through a read-data register, and polls a status register. Pushing when full or popping when empty is reported with PSLVERR.

Parameters:
DATA_W, 8, FIFO entry width; 1..32; stored from PWDATA[DATA_W-1:0], returned zero-extended on PRDATA.
DEPTH, 4, FIFO entries; power of two, 2..128.
ADDR_W, 4, PADDR width decoded by the block.

Ports:
PCLK  in  1  bus clock; all state updates on the rising edge.
PRESET  in  1  synchronous active-high reset.
PADDR  in  ADDR_W  byte address; bits [1:0] ignored.
PSEL  in  1  block select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1 = write, 0 = read.
PWDATA  in  32  write data.
PRDATA  out  32  read data; registered.
PREADY  out  1  transfer complete; registered.
PSLVERR  out  1  error; registered; meaningful only while PREADY=1.

Behaviour:
- Clock and reset: one clock, PCLK. PRESET is synchronous and active-high.
- Register map:
  - 0x0 FSR, read-only: bit0 empty, bit1 full, bits[15:8] count; all other bits 0; writes ignored with no error.
  - 0x4 FWD, write pushes; reads return 0.
  - 0x8 FRD, read pops; writes ignored with no error.
  - 0xC, or any unmapped offset: reads return 0, PSLVERR=0.
- Reset: on the PCLK edge with PRESET=1, PREADY=0, PRDATA=0, PSLVERR=0, FSM=IDLE, pointers=0, count=0. Storage contents are don't-care. PRESET during an access abandons it with no push or pop; the master must restart.
- FSM states:
  - IDLE: on PSEL=1 and PENABLE=0 (setup phase), go to RESP.
  - RESP: PREADY=1 for exactly one cycle; the transfer completes in this cycle; next state is IDLE.
  - Zero-wait timing: setup cycle, then access cycle with PREADY=1.
- Response registers, loaded on the setup-cycle edge into RESP:
  - PRDATA = decoded read value. For FRD this is the FIFO head (show-ahead), zero-extended.
  - PSLVERR = 1 for an FWD write when full, or an FRD read when empty; else 0.
  - Outside RESP: PREADY=0, PRDATA=0, PSLVERR=0.
- Side effects: the push or pop happens on the edge that ends the RESP cycle, only when PSEL & PENABLE are high and PSLVERR=0. A push when full drops the data. A pop when empty returns PRDATA=0 and does not move pointers.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits, range 0..DEPTH. full = (count==DEPTH); empty = (count==0).
- Simultaneous push and pop cannot occur: at most one APB transfer is in flight.
- PSEL dropped in RESP (protocol violation): no side effect; return to IDLE.

Optional Feature:
APB_FIFO_WAIT_EN
- Defined: an extra state WAIT is inserted between IDLE and RESP. The access phase holds PREADY=0 for one cycle, then 1, so each transfer takes 3 cycles. Response registers are loaded on the edge into RESP, so status is sampled one cycle later.
- Undefined: WAIT is absent; zero-wait timing as above.

Decomposition:
- apb_fifo_pkg: register offsets FSR_OFS/FWD_OFS/FRD_OFS, FSR bit positions, state enum typedef (IDLE, WAIT, RESP).
- Sub-module fifo_sync (DATA_W, DEPTH): push, pop, wdata, rdata (show-ahead head), full, empty, count. Overflow and underflow are guarded inside it as well.

Test Plan:
- Reset: hold PRESET 2 cycles -> PREADY=0, PRDATA=0, PSLVERR=0; read FSR -> 0x00000001.
- Push then pop: write FWD 0x11, then 0x22 -> FSR 0x00000200; read FRD twice -> 0x11 then 0x22, PSLVERR=0; FSR -> 0x00000001.
- Overflow (DEPTH=4): write 0xA0..0xA3 -> FSR 0x00000402; write 0xFF -> PSLVERR=1, FSR unchanged; 4 FRD reads -> 0xA0..0xA3.
- Underflow: FRD on empty -> PRDATA=0, PSLVERR=1, FSR stays 0x00000001; subsequent write and read work normally.
- Wrap: push/pop 3, then push 0xB0..0xB3 -> pops return 0xB0..0xB3 in order; full flag set at the 4th push.
- Reset mid-access: assert PRESET in the setup cycle of an FWD write -> no push, FSR reads 0x00000001; with APB_FIFO_WAIT_EN defined, PREADY is low for the first access cycle on every transfer.
